alu_host_seq: RTL and testbench

Initiator-side sequencer for the 4-bit ALU interface. It accepts operation commands over a valid/ready port and drives the ALU operand bus (y in bits [7:4], x in bits [3:0]) and the 8-bit opcode bus. It waits a programmable settle time, captures the ALU result, and returns it on a valid/ready response port. It sits between the host-side command logic and the combinational ALU and owns all ALU bus timing.

---
 rtl/alu_host_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_host_seq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_host_seq.sv
// ---------------------------------------------------------------------------
// alu_host_seq -- initiator-side sequencer for the 4-bit combinational ALU.
//
// It accepts one command at a time on a valid/ready port and drives the ALU
// operand and opcode buses. After SETTLE_CYCLES clock edges it captures the
// ALU result and presents it on a valid/ready response port. All ALU bus
// timing is owned here. Every output is registered.
//
// Parameters:
//   SETTLE_CYCLES  clock edges from driving the ALU bus to capturing the
//                  result (legal range 1..15)
//
// Optional build macro:
//   ALU_HOST_DIVZERO_EN  when defined, divide (op 3) and modulo (op 10) with
//                        y == 0 are answered locally as an error response
//                        (data 0xFF, rsp_err 1). The ALU bus is not touched.
//                        When undefined, every command goes to the ALU and
//                        rsp_err is tied to 0.
//
// Ports:
//   clk           clock
//   rst_n         synchronous, active-low reset
//   cmd_valid     command present
//   cmd_ready     sequencer can accept a command
//   cmd_op        ALU opcode (0..12 defined, 13..15 passed through)
//   cmd_x         operand x
//   cmd_y         operand y
//   alu_operands  {y, x} to the ALU
//   alu_opcode    zero-extended opcode to the ALU (0xFF = idle)
//   alu_result    ALU result
//   rsp_valid     response present
//   rsp_ready     consumer accepts the response
//   rsp_data      captured result
//   rsp_err       command was rejected locally
//   done_count    completed responses, wrapping at 8 bits
// ---------------------------------------------------------------------------
module alu_host_seq #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_x,
    input  logic [3:0] cmd_y,
    output logic [7:0] alu_operands,
    output logic [7:0] alu_opcode,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic [7:0] done_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // The ALU returns 0 for this opcode, so it is a safe bus value when idle.
    localparam logic [7:0] IDLE_OPCODE = 8'hFF;

    // Counter load at acceptance: capture happens on the edge where the
    // counter reads zero, which is exactly SETTLE_CYCLES edges later.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [1:0] r_state;
    logic [3:0] r_settle_cnt;
    logic       r_cmd_ready;
    logic [7:0] r_operands;
    logic [7:0] r_opcode;
    logic       r_rsp_valid;
    logic [7:0] r_rsp_data;
    logic [7:0] r_done_count;

`ifdef ALU_HOST_DIVZERO_EN
    logic r_rsp_err;
    logic w_divzero;

    // Division and modulo by zero are answered without using the ALU.
    assign w_divzero = ((cmd_op == 4'd3) || (cmd_op == 4'd10)) && (cmd_y == 4'd0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 4'd0;
            r_cmd_ready  <= 1'b0;
            r_operands   <= 8'h00;
            r_opcode     <= IDLE_OPCODE;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 8'h00;
            r_done_count <= 8'h00;
`ifdef ALU_HOST_DIVZERO_EN
            r_rsp_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // cmd_ready is registered, so the first IDLE cycle after
                    // reset only raises it; acceptance needs it already high.
                    if (!r_cmd_ready) begin
                        r_cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
`ifdef ALU_HOST_DIVZERO_EN
                        if (w_divzero) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= 8'hFF;
                            r_rsp_err   <= 1'b1;
                            r_state     <= ST_RESP;
                        end else
`endif
                        begin
                            r_operands   <= {cmd_y, cmd_x};
                            r_opcode     <= {4'b0000, cmd_op};
                            r_settle_cnt <= SETTLE_LOAD;
                            r_state      <= ST_SETTLE;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (r_settle_cnt == 4'd0) begin
                        r_rsp_data  <= alu_result;
                        r_rsp_valid <= 1'b1;
`ifdef ALU_HOST_DIVZERO_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= ST_RESP;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end

                ST_RESP: begin
                    // cmd_ready is raised here but the command port is only
                    // looked at from IDLE, so nothing is accepted on the
                    // handshake edge itself.
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_done_count <= r_done_count + 8'd1;
                        r_operands   <= 8'h00;
                        r_opcode     <= IDLE_OPCODE;
                        r_cmd_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_operands  <= 8'h00;
                    r_opcode    <= IDLE_OPCODE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign alu_operands = r_operands;
    assign alu_opcode   = r_opcode;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign done_count   = r_done_count;
`ifdef ALU_HOST_DIVZERO_EN
    assign rsp_err      = r_rsp_err;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_alu_host_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_host_seq -- directed bench for alu_host_seq.
//
// Two instances share clk/rst_n: dut (SETTLE_CYCLES=1) is fed by a small
// behavioural ALU, dut4 (SETTLE_CYCLES=4) sees an alu_result that the bench
// changes every cycle so the capture edge can be pinned down.
// ---------------------------------------------------------------------------
module tb_alu_host_seq;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_valid4;
    logic [3:0] cmd_op;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       rsp_ready;
    logic       rsp_ready4;
    logic [7:0] alu_res;
    logic [7:0] alu_res4;

    logic       cmd_ready,    cmd_ready4;
    logic [7:0] alu_operands, alu_operands4;
    logic [7:0] alu_opcode,   alu_opcode4;
    logic       rsp_valid,    rsp_valid4;
    logic [7:0] rsp_data,     rsp_data4;
    logic       rsp_err,      rsp_err4;
    logic [7:0] done_count,   done_count4;

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: add, sub, mul, div, xor, mod; everything else (incl.
    // the 0xFF idle code and 13..15) returns 0. Division by zero returns 0.
    function automatic logic [7:0] alu_model(input logic [7:0] ops, input logic [7:0] opc);
        logic [7:0] x;
        logic [7:0] y;
        x = {4'b0000, ops[3:0]};
        y = {4'b0000, ops[7:4]};
        case (opc)
            8'd0:    return x + y;
            8'd1:    return x - y;
            8'd2:    return x * y;
            8'd3:    return (y == 8'd0) ? 8'h00 : x / y;
            8'd6:    return x ^ y;
            8'd10:   return (y == 8'd0) ? 8'h00 : x % y;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res = alu_model(alu_operands, alu_opcode);

    alu_host_seq #(.SETTLE_CYCLES(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .alu_operands (alu_operands),
        .alu_opcode   (alu_opcode),
        .alu_result   (alu_res),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .done_count   (done_count)
    );

    alu_host_seq #(.SETTLE_CYCLES(4)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid4),
        .cmd_ready    (cmd_ready4),
        .cmd_op       (cmd_op),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .alu_operands (alu_operands4),
        .alu_opcode   (alu_opcode4),
        .alu_result   (alu_res4),
        .rsp_valid    (rsp_valid4),
        .rsp_ready    (rsp_ready4),
        .rsp_data     (rsp_data4),
        .rsp_err      (rsp_err4),
        .done_count   (done_count4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready); else n_pass++;
        n_checks++; if (alu_operands !== 8'h00) $display("FAIL reset_operands got=%h exp=00", alu_operands); else n_pass++;
        n_checks++; if (alu_opcode !== 8'hFF) $display("FAIL reset_opcode got=%h exp=ff", alu_opcode); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 8'h00) $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else n_pass++;
        n_checks++; if (done_count !== 8'h00) $display("FAIL reset_done got=%h exp=00", done_count); else n_pass++;
        rst_n = 1'b1;
        tick();
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL idle_cmd_ready got=%b exp=1", cmd_ready); else n_pass++;
        n_checks++; if (cmd_ready4 !== 1'b1) $display("FAIL idle_cmd_ready4 got=%b exp=1", cmd_ready4); else n_pass++;
        $display("txn reset done");
    endtask

    task automatic test_add;
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_x = 4'd7; cmd_y = 4'd5; rsp_ready = 1'b1;
        tick();                                   // acceptance edge
        cmd_valid = 1'b0;
        n_checks++; if (alu_operands !== 8'h57) $display("FAIL add_operands got=%h exp=57", alu_operands); else n_pass++;
        n_checks++; if (alu_opcode !== 8'h00) $display("FAIL add_opcode got=%h exp=00", alu_opcode); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL add_busy got=%b exp=0", cmd_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_early_valid got=%b exp=0", rsp_valid); else n_pass++;
        tick();                                   // capture edge
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL add_valid got=%b exp=1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 8'h0C) $display("FAIL add_data got=%h exp=0c", rsp_data); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL add_err got=%b exp=0", rsp_err); else n_pass++;
        tick();                                   // handshake edge
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL add_valid_drop got=%b exp=0", rsp_valid); else n_pass++;
        n_checks++; if (done_count !== 8'h01) $display("FAIL add_done got=%h exp=01", done_count); else n_pass++;
        n_checks++; if (alu_opcode !== 8'hFF) $display("FAIL add_idle_opcode got=%h exp=ff", alu_opcode); else n_pass++;
        n_checks++; if (alu_operands !== 8'h00) $display("FAIL add_idle_operands got=%h exp=00", alu_operands); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL add_ready_back got=%b exp=1", cmd_ready); else n_pass++;
        $display("txn add x=7 y=5 rsp=%h", rsp_data);
    endtask

    task automatic test_back_to_back;
        cmd_valid = 1'b1; cmd_op = 4'd1; cmd_x = 4'd3; cmd_y = 4'd5; rsp_ready = 1'b1;
        tick();                                   // accept sub
        cmd_op = 4'd2; cmd_x = 4'd15; cmd_y = 4'd15;   // next command waits with valid high
        n_checks++; if (alu_opcode !== 8'h01) $display("FAIL b2b_sub_opcode got=%h exp=01", alu_opcode); else n_pass++;
        tick();                                   // capture sub
        n_checks++; if (rsp_data !== 8'hFE) $display("FAIL b2b_sub_data got=%h exp=fe", rsp_data); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b0) $display("FAIL b2b_ready_in_resp got=%b exp=0", cmd_ready); else n_pass++;
        $display("txn sub x=3 y=5 rsp=%h", rsp_data);
        tick();                                   // handshake, no acceptance here
        n_checks++; if (alu_opcode !== 8'hFF) $display("FAIL b2b_no_accept_hs got=%h exp=ff", alu_opcode); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after_hs got=%b exp=1", cmd_ready); else n_pass++;
        n_checks++; if (done_count !== 8'h02) $display("FAIL b2b_done1 got=%h exp=02", done_count); else n_pass++;
        tick();                                   // accept mul
        cmd_valid = 1'b0;
        n_checks++; if (alu_operands !== 8'hFF) $display("FAIL b2b_mul_operands got=%h exp=ff", alu_operands); else n_pass++;
        n_checks++; if (alu_opcode !== 8'h02) $display("FAIL b2b_mul_opcode got=%h exp=02", alu_opcode); else n_pass++;
        tick();                                   // capture mul
        n_checks++; if (rsp_data !== 8'hE1) $display("FAIL b2b_mul_data got=%h exp=e1", rsp_data); else n_pass++;
        $display("txn mul x=15 y=15 rsp=%h", rsp_data);
        tick();
        n_checks++; if (done_count !== 8'h03) $display("FAIL b2b_done2 got=%h exp=03", done_count); else n_pass++;
    endtask

    task automatic test_backpressure;
        cmd_valid = 1'b1; cmd_op = 4'd6; cmd_x = 4'hA; cmd_y = 4'h6; rsp_ready = 1'b0;
        tick();                                   // accept
        cmd_x = 4'h3; cmd_op = 4'd0;              // must be ignored while busy
        tick();                                   // capture
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got=%b exp=1", i, rsp_valid); else n_pass++;
            n_checks++; if (rsp_data !== 8'h0C) $display("FAIL bp_data[%0d] got=%h exp=0c", i, rsp_data); else n_pass++;
            n_checks++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready[%0d] got=%b exp=0", i, cmd_ready); else n_pass++;
            n_checks++; if (done_count !== 8'h03) $display("FAIL bp_done[%0d] got=%h exp=03", i, done_count); else n_pass++;
            n_checks++; if (alu_operands !== 8'h6A) $display("FAIL bp_bus[%0d] got=%h exp=6a", i, alu_operands); else n_pass++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL bp_release_valid got=%b exp=0", rsp_valid); else n_pass++;
        n_checks++; if (done_count !== 8'h04) $display("FAIL bp_release_done got=%h exp=04", done_count); else n_pass++;
        tick();
        n_checks++; if (done_count !== 8'h04) $display("FAIL bp_single_hs got=%h exp=04", done_count); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL bp_idle got=%b exp=1", cmd_ready); else n_pass++;
        $display("txn xor x=a y=6 rsp=0c after backpressure");
        rsp_ready = 1'b0;
    endtask

    task automatic test_undefined_op;
        cmd_valid = 1'b1; cmd_op = 4'd13; cmd_x = 4'd1; cmd_y = 4'd1; rsp_ready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (alu_opcode !== 8'h0D) $display("FAIL op13_opcode got=%h exp=0d", alu_opcode); else n_pass++;
        tick();
        n_checks++; if (rsp_data !== 8'h00) $display("FAIL op13_data got=%h exp=00", rsp_data); else n_pass++;
        $display("txn op13 rsp=%h", rsp_data);
        tick();
        n_checks++; if (done_count !== 8'h05) $display("FAIL op13_done got=%h exp=05", done_count); else n_pass++;
    endtask

    task automatic test_divzero;
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_x = 4'd9; cmd_y = 4'd0; rsp_ready = 1'b0;
        tick();                                   // acceptance edge
        cmd_valid = 1'b0;
`ifdef ALU_HOST_DIVZERO_EN
        n_checks++; if (alu_opcode !== 8'hFF) $display("FAIL dz_opcode got=%h exp=ff", alu_opcode); else n_pass++;
        n_checks++; if (alu_operands !== 8'h00) $display("FAIL dz_operands got=%h exp=00", alu_operands); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL dz_valid got=%b exp=1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 8'hFF) $display("FAIL dz_data got=%h exp=ff", rsp_data); else n_pass++;
        n_checks++; if (rsp_err !== 1'b1) $display("FAIL dz_err got=%b exp=1", rsp_err); else n_pass++;
`else
        n_checks++; if (alu_opcode !== 8'h03) $display("FAIL dz_opcode got=%h exp=03", alu_opcode); else n_pass++;
        n_checks++; if (alu_operands !== 8'h09) $display("FAIL dz_operands got=%h exp=09", alu_operands); else n_pass++;
        tick();                                   // capture
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL dz_valid got=%b exp=1", rsp_valid); else n_pass++;
        n_checks++; if (rsp_data !== 8'h00) $display("FAIL dz_data got=%h exp=00", rsp_data); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL dz_err got=%b exp=0", rsp_err); else n_pass++;
`endif
        $display("txn div x=9 y=0 rsp=%h err=%b", rsp_data, rsp_err);
        rsp_ready = 1'b1;
        tick();
        n_checks++; if (done_count !== 8'h06) $display("FAIL dz_done got=%h exp=06", done_count); else n_pass++;
        // A legal division still goes through the ALU with no error.
        cmd_valid = 1'b1; cmd_op = 4'd3; cmd_x = 4'd9; cmd_y = 4'd3;
        tick();
        cmd_valid = 1'b0;
        n_checks++; if (alu_opcode !== 8'h03) $display("FAIL div_opcode got=%h exp=03", alu_opcode); else n_pass++;
        tick();
        n_checks++; if (rsp_data !== 8'h03) $display("FAIL div_data got=%h exp=03", rsp_data); else n_pass++;
        n_checks++; if (rsp_err !== 1'b0) $display("FAIL div_err got=%b exp=0", rsp_err); else n_pass++;
        $display("txn div x=9 y=3 rsp=%h err=%b", rsp_data, rsp_err);
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_settle4;
        alu_res4 = 8'hA0;
        cmd_valid4 = 1'b1; cmd_op = 4'd0; cmd_x = 4'd1; cmd_y = 4'd2; rsp_ready4 = 1'b0;
        tick();                                   // acceptance edge
        cmd_valid4 = 1'b0;
        n_checks++; if (alu_operands4 !== 8'h21) $display("FAIL s4_operands got=%h exp=21", alu_operands4); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            alu_res4 = 8'hA0 + 8'(k);             // value seen at the k-th edge
            tick();
            if (k < 4) begin
                n_checks++; if (rsp_valid4 !== 1'b0) $display("FAIL s4_early_valid[%0d] got=%b exp=0", k, rsp_valid4); else n_pass++;
                n_checks++; if (alu_operands4 !== 8'h21) $display("FAIL s4_bus_hold[%0d] got=%h exp=21", k, alu_operands4); else n_pass++;
            end
        end
        n_checks++; if (rsp_valid4 !== 1'b1) $display("FAIL s4_valid got=%b exp=1", rsp_valid4); else n_pass++;
        n_checks++; if (rsp_data4 !== 8'hA4) $display("FAIL s4_data got=%h exp=a4", rsp_data4); else n_pass++;
        alu_res4 = 8'h55;
        tick();
        n_checks++; if (rsp_data4 !== 8'hA4) $display("FAIL s4_hold got=%h exp=a4", rsp_data4); else n_pass++;
        $display("txn settle4 rsp=%h", rsp_data4);
        rsp_ready4 = 1'b1;
        tick();
        n_checks++; if (done_count4 !== 8'h01) $display("FAIL s4_done got=%h exp=01", done_count4); else n_pass++;
        rsp_ready4 = 1'b0;
    endtask

    task automatic test_reset_midop;
        int seen_valid;
        cmd_valid4 = 1'b1; cmd_op = 4'd0; cmd_x = 4'd3; cmd_y = 4'd3;
        tick();                                   // accept on dut4
        cmd_valid4 = 1'b0;
        tick();                                   // still settling
        n_checks++; if (rsp_valid4 !== 1'b0) $display("FAIL mid_pre_valid got=%b exp=0", rsp_valid4); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if (rsp_valid4 !== 1'b0) $display("FAIL mid_valid got=%b exp=0", rsp_valid4); else n_pass++;
        n_checks++; if (alu_opcode4 !== 8'hFF) $display("FAIL mid_opcode got=%h exp=ff", alu_opcode4); else n_pass++;
        n_checks++; if (done_count4 !== 8'h00) $display("FAIL mid_done4 got=%h exp=00", done_count4); else n_pass++;
        n_checks++; if (done_count !== 8'h00) $display("FAIL mid_done got=%h exp=00", done_count); else n_pass++;
        n_checks++; if (cmd_ready4 !== 1'b0) $display("FAIL mid_ready got=%b exp=0", cmd_ready4); else n_pass++;
        rst_n = 1'b1;
        rsp_ready4 = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rsp_valid4 === 1'b1) seen_valid++;
        end
        n_checks++; if (seen_valid != 0) $display("FAIL mid_no_resp got=%0d exp=0", seen_valid); else n_pass++;
        n_checks++; if (done_count4 !== 8'h00) $display("FAIL mid_done_after got=%h exp=00", done_count4); else n_pass++;
        $display("txn reset during settle, response discarded");
        rsp_ready4 = 1'b0;
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();                                   // cmd_ready rises
        cmd_valid = 1'b1; cmd_op = 4'd0; cmd_x = 4'd1; cmd_y = 4'd1; rsp_ready = 1'b1;
        // Each command takes exactly 3 cycles: accept, capture, handshake.
        for (int c = 1; c <= 768; c++) begin
            tick();
            if (c == 765) begin
                n_checks++; if (done_count !== 8'hFF) $display("FAIL wrap_ff got=%h exp=ff", done_count); else n_pass++;
            end
        end
        cmd_valid = 1'b0;
        n_checks++; if (done_count !== 8'h00) $display("FAIL wrap_zero got=%h exp=00", done_count); else n_pass++;
        n_checks++; if (cmd_ready !== 1'b1) $display("FAIL wrap_idle got=%b exp=1", cmd_ready); else n_pass++;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL wrap_valid got=%b exp=0", rsp_valid); else n_pass++;
        $display("txn 256 commands, done_count=%h", done_count);
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_valid4 = 1'b0;
        cmd_op     = 4'd0;
        cmd_x      = 4'd0;
        cmd_y      = 4'd0;
        rsp_ready  = 1'b0;
        rsp_ready4 = 1'b0;
        alu_res4   = 8'h00;
        #2;
        test_reset();
        test_add();
        test_back_to_back();
        test_backpressure();
        test_undefined_op();
        test_divzero();
        test_settle4();
        test_reset_midop();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
